// File: rtl/param_down_counter.sv
// Loadable down-counter/timer: counts a loaded value down to 0, pulses underflow,
// then stops (one-shot) or reloads (periodic).
module param_down_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             periodic,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reload;
    logic             r_busy;
    logic             r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_reload    <= '0;
            r_busy      <= 1'b0;
            r_underflow <= 1'b0;
        end else if (load) begin
            // A zero load parks the timer rather than arming an immediate wrap.
            r_count     <= load_val;
            r_reload    <= load_val;
            r_underflow <= 1'b0;
            if (load_val != '0) begin
                r_state <= RUN;
                r_busy  <= 1'b1;
            end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (en && r_count != '0) begin
                        r_count     <= r_count - CNT_W'(1);
                        r_underflow <= 1'b0;
                    end else if (en) begin
                        r_underflow <= 1'b1;
                        if (periodic) begin
                            r_count <= r_reload;
                        end else begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_underflow <= 1'b0;
                    end
                end
                default: begin
                    r_underflow <= 1'b0;
                end
            endcase
        end
    end

    assign count     = r_count;
    assign busy      = r_busy;
    assign underflow = r_underflow;

endmodule
